// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state
// encoding, requester identifiers and the memsize access-size encoding.
package mem_arb_pkg;

    // Arbiter FSM states; one memory transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Requester identifiers; the value doubles as a bit index into
    // per-requester gnt/rvalid vectors.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // memsize encoding: bit 2 = unsigned, bits 1:0 = log2(bytes).
    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

    // Bits needed to hold a counter that saturates at max_val (min 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the shared memory
// and the arbiter. The arbiter connects through the slave modport; the
// surrounding core/memory environment uses the master modport.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    // Fetch port
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    // Data port
    logic            d_req;
    logic            d_we;
    logic [2:0]      d_size;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    // Shared memory port
    logic            mem_req;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: purely combinational winner selection between the fetch and
// data requesters.
// Build option ARB_RR_EN: when defined, ties go to the requester that was
// not granted last; otherwise data has priority unless the fetch side has
// been starved for STARVE_MAX consecutive data grants.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             d_req,
`ifdef ARB_RR_EN
    input  req_id_t          last_gnt,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             valid,
    output req_id_t          winner
);

`ifndef ARB_RR_EN
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
`endif

    // Choose a winner whenever at least one requester is asking.
    always_comb begin
        valid  = if_req | d_req;
        winner = REQ_IF;
`ifdef ARB_RR_EN
        if (if_req && d_req) begin
            // Tie: alternate away from whoever was served last.
            winner = (last_gnt == REQ_IF) ? REQ_D : REQ_IF;
        end else if (d_req) begin
            winner = REQ_D;
        end
`else
        if (d_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
            winner = REQ_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data requester. One transaction is outstanding at a
// time: grant in IDLE, hold the registered request in BUSY_* until
// mem_ready, then return the registered read data in RESP.
// Build option ARB_RR_EN selects round-robin arbitration; the default
// build uses fixed data priority with a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hlt,
    output logic              idle,
    mem_port_arbiter_if.slave bus
);

    arb_state_t      state_reg;
    arb_state_t      state_next;

    // Held low by reset and set on the first clock afterwards, so no grant
    // can appear combinationally while rst_n is asserted.
    logic            run_reg;

    req_id_t         last_gnt_reg;
    logic            mem_we_reg;
    logic [2:0]      mem_size_reg;
    logic [XLEN-1:0] mem_addr_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic [XLEN-1:0] rdata_reg;

    logic            pick_valid;
    req_id_t         pick_id;
    logic            grant;
    logic            busy;
    logic [1:0]      gnt_vec;
    logic [1:0]      rvalid_vec;

    assign busy = (state_reg == BUSY_IF) || (state_reg == BUSY_D);

`ifdef ARB_RR_EN
    arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (1)
    ) u_pick (
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .last_gnt (last_gnt_reg),
        .valid    (pick_valid),
        .winner   (pick_id)
    );
`else
    localparam int               CNT_W      = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_reg;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_reg),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    // Count data grants that bypassed a waiting fetch; any fetch grant or
    // a withdrawn fetch request resets the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
        end else if (!bus.if_req || gnt_vec[REQ_IF]) begin
            starve_reg <= '0;
        end else if (gnt_vec[REQ_D] && (starve_reg != STARVE_LIM)) begin
            starve_reg <= starve_reg + CNT_W'(1);
        end
    end
`endif

    // Fan the single grant / response event out to per-requester pulses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]    = grant && (pick_id == req_id_t'(1'(gi)));
        assign rvalid_vec[gi] = (state_reg == RESP) &&
                                (last_gnt_reg == req_id_t'(1'(gi)));
    end

    // Next-state logic; grants are only ever issued from IDLE.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (run_reg && !hlt && pick_valid) begin
                    grant      = 1'b1;
                    state_next = (pick_id == REQ_D) ? BUSY_D : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    // Capture the winning requester's fields at grant time so the memory
    // sees stable values for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg  <= REQ_IF;
            mem_we_reg    <= 1'b0;
            mem_size_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (grant) begin
            last_gnt_reg <= pick_id;
            if (pick_id == REQ_D) begin
                mem_we_reg    <= bus.d_we;
                mem_size_reg  <= bus.d_size;
                mem_addr_reg  <= bus.d_addr;
                mem_wdata_reg <= bus.d_wdata;
            end else begin
                mem_we_reg    <= 1'b0;
                mem_size_reg  <= MEM_SIZE_W;
                mem_addr_reg  <= bus.if_addr;
                mem_wdata_reg <= '0;
            end
        end
    end

    // Register the memory's read data on completion; stores return zero.
    // mem_ready is only honoured while a request is actually outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (busy && bus.mem_ready) begin
            rdata_reg <= mem_we_reg ? '0 : bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = gnt_vec[REQ_IF];
    assign bus.d_gnt     = gnt_vec[REQ_D];
    assign bus.if_rvalid = rvalid_vec[REQ_IF];
    assign bus.d_rvalid  = rvalid_vec[REQ_D];
    assign bus.if_rdata  = rdata_reg;
    assign bus.d_rdata   = rdata_reg;

    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_size  = mem_size_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;

    assign idle = (state_reg == IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset values, single fetch
// latency, store with hlt, back-to-back arbitration order and reset in
// the middle of a data transaction. Expected grant order depends on
// ARB_RR_EN.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    logic hlt;
    logic idle;
    logic auto_ready;
    logic ready_drv;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    // Memory model: either a 0-wait echo of mem_req or a hand-driven strobe.
    assign bus.mem_ready = auto_ready ? bus.mem_req : ready_drv;

    mem_port_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hlt   (hlt),
        .idle  (idle),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are read at the
    // falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int last_cyc;
        logic pend_d;
        logic exp_d;

        rst_n          = 1'b0;
        hlt            = 1'b0;
        auto_ready     = 1'b0;
        ready_drv      = 1'b0;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_size     = 3'b010;
        bus.d_addr     = 32'h0;
        bus.d_wdata    = 32'h0;
        bus.mem_rdata  = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) next_cycle();
        sample();
        check_val("rst_idle",     idle,           1);
        check_val("rst_if_gnt",   bus.if_gnt,     0);
        check_val("rst_d_gnt",    bus.d_gnt,      0);
        check_val("rst_mem_req",  bus.mem_req,    0);
        check_val("rst_mem_we",   bus.mem_we,     0);
        check_val("rst_mem_addr", bus.mem_addr,   0);
        check_val("rst_if_rdata", bus.if_rdata,   0);
        check_val("rst_if_rval",  bus.if_rvalid,  0);
        $display("[TB] reset held: idle=%0d mem_req=%0d", idle, bus.mem_req);
        next_cycle();
        bus.if_req = 1'b0;
        rst_n      = 1'b1;
        repeat (2) next_cycle();

        // ---------------- single fetch ----------------
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        sample();
        check_val("f_if_gnt", bus.if_gnt, 1);
        check_val("f_d_gnt",  bus.d_gnt,  0);
        next_cycle();
        bus.if_req = 1'b0;
        sample();
        check_val("f_mem_req",  bus.mem_req,  1);
        check_val("f_mem_addr", bus.mem_addr, 32'h100);
        check_val("f_mem_we",   bus.mem_we,   0);
        check_val("f_no_gnt",   bus.if_gnt,   0);
        next_cycle();
        ready_drv     = 1'b1;
        bus.mem_rdata = 32'h00500093;
        sample();
        check_val("f_mem_req2", bus.mem_req,   1);
        check_val("f_early_rv", bus.if_rvalid, 0);
        next_cycle();
        ready_drv     = 1'b0;
        bus.mem_rdata = 32'h0;
        sample();
        check_val("f_if_rvalid", bus.if_rvalid, 1);
        check_val("f_if_rdata",  bus.if_rdata,  32'h00500093);
        check_val("f_d_rvalid",  bus.d_rvalid,  0);
        check_val("f_req_drop",  bus.mem_req,   0);
        $display("[TB] fetch addr=0x100 rdata=0x%08h", bus.if_rdata);
        next_cycle();
        sample();
        check_val("f_rv_pulse", bus.if_rvalid, 0);
        check_val("f_idle",     idle,          1);

        // ---------------- store with hlt ----------------
        next_cycle();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_size  = 3'b010;
        sample();
        check_val("s_d_gnt",  bus.d_gnt,  1);
        check_val("s_if_gnt", bus.if_gnt, 0);
        next_cycle();
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        hlt        = 1'b1;
        bus.if_req = 1'b1;
        sample();
        check_val("s_mem_req",   bus.mem_req,   1);
        check_val("s_mem_we",    bus.mem_we,    1);
        check_val("s_mem_addr",  bus.mem_addr,  32'h200);
        check_val("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check_val("s_mem_size",  bus.mem_size,  3'b010);
        check_val("s_busy_gnt",  bus.if_gnt,    0);
        next_cycle();
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        sample();
        check_val("s_hold_addr",  bus.mem_addr,  32'h200);
        check_val("s_hold_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check_val("s_hold_we",    bus.mem_we,    1);
        next_cycle();
        ready_drv     = 1'b1;
        bus.mem_rdata = 32'h12345678;
        sample();
        check_val("s_mem_req2", bus.mem_req, 1);
        next_cycle();
        ready_drv = 1'b0;
        sample();
        check_val("s_d_rvalid", bus.d_rvalid,  1);
        check_val("s_d_rdata",  bus.d_rdata,   0);
        check_val("s_if_rval",  bus.if_rvalid, 0);
        $display("[TB] store addr=0x200 data=0xdeadbeef d_rdata=0x%08h", bus.d_rdata);
        next_cycle();
        ready_drv = 1'b1;
        sample();
        check_val("h_no_gnt1", bus.if_gnt, 0);
        check_val("h_idle",    idle,       1);
        next_cycle();
        ready_drv = 1'b0;
        sample();
        check_val("h_no_gnt2",   bus.if_gnt,    0);
        check_val("h_stray_drv", bus.d_rvalid,  0);
        check_val("h_stray_irv", bus.if_rvalid, 0);
        check_val("h_mem_req",   bus.mem_req,   0);
        next_cycle();
        hlt           = 1'b0;
        auto_ready    = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        sample();
        check_val("h_release_gnt", bus.if_gnt, 1);
        next_cycle();
        bus.if_req = 1'b0;
        sample();
        check_val("h_f_addr", bus.mem_addr, 32'h100);
        next_cycle();
        sample();
        check_val("h_f_rvalid", bus.if_rvalid, 1);
        check_val("h_f_rdata",  bus.if_rdata,  32'hCAFE0001);
        $display("[TB] fetch after hlt rdata=0x%08h", bus.if_rdata);

        // ---------------- continuous contention ----------------
        next_cycle();
        bus.if_req    = 1'b1;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h300;
        bus.mem_rdata = 32'h00000A5A;
        n        = 0;
        last_cyc = 0;
        pend_d   = 1'b0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            sample();
            check_val("c_onehot", bus.if_gnt & bus.d_gnt, 0);
            if (bus.if_rvalid || bus.d_rvalid) begin
                check_val("c_rvalid_id", bus.d_rvalid, pend_d);
                if (bus.d_rvalid) check_val("c_d_rdata", bus.d_rdata, 32'h00000A5A);
            end
            if (bus.if_gnt || bus.d_gnt) begin
`ifdef ARB_RR_EN
                exp_d = ((n % 2) == 0);
`else
                exp_d = ((n % 5) != 4);
`endif
                check_val("c_gnt_id", bus.d_gnt, exp_d);
                if (n > 0) check_val("c_gap", cyc - last_cyc, 3);
                $display("[TB] grant %0d -> %s at cycle %0d", n,
                         bus.d_gnt ? "D" : "IF", cyc);
                last_cyc = cyc;
                pend_d   = bus.d_gnt;
                n++;
            end
        end
        check_val("c_count", n, 10);
        next_cycle();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (4) next_cycle();
        sample();
        check_val("c_idle", idle, 1);

        // ---------------- reset during BUSY_D ----------------
        next_cycle();
        auto_ready = 1'b0;
        ready_drv  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h400;
        sample();
        check_val("r_d_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req = 1'b0;
        #2;
        check_val("r_pre_req", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        check_val("r_req_drop", bus.mem_req,  0);
        check_val("r_idle",     idle,         1);
        check_val("r_addr_clr", bus.mem_addr, 0);
        $display("[TB] reset mid-transaction: mem_req=%0d", bus.mem_req);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ready_drv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            check_val("r_no_drv", bus.d_rvalid,  0);
            check_val("r_no_irv", bus.if_rvalid, 0);
            next_cycle();
            ready_drv = 1'b0;
        end
        sample();
        check_val("r_idle_end", idle, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
